up_counter_ctrl: RTL and testbench



---
 rtl/up_counter_ctrl_pkg.sv | 13 +
 rtl/up_counter_ctrl.sv | 87 ++++++++
 tb/tb_up_counter_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/up_counter_ctrl_pkg.sv
// Shared constants and state encoding for the controlled up counter.
package up_counter_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LIMIT = 2**DEF_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/up_counter_ctrl.sv
// Controlled up counter with start/stop FSM, loadable clamped start value.
// Define UP_COUNTER_CTRL_AUTO_RELOAD_EN to wrap to 0 at LIMIT instead of stopping in DONE.
module up_counter_ctrl
    import up_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] LIM = LIMIT[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ld_clamp;

    assign ld_clamp = (load_val > LIM) ? LIM : load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (load)  q_d     = ld_clamp;
                if (start) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    q_d = ld_clamp;
                end else if (q_q == LIM) begin
`ifdef UP_COUNTER_CTRL_AUTO_RELOAD_EN
                    q_d = '0;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                // load decides the value; start alone restarts from zero
                if (load) begin
                    q_d     = ld_clamp;
                    state_d = start ? ST_COUNT : ST_IDLE;
                end else if (start) begin
                    q_d     = '0;
                    state_d = ST_COUNT;
                end else if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign q    = q_q;
    assign busy = (state_q == ST_COUNT);
    assign tc   = (state_q == ST_COUNT) && (q_q == LIM);
`ifdef UP_COUNTER_CTRL_AUTO_RELOAD_EN
    assign done = 1'b0;
`else
    assign done = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed bench: one LIMIT=15 and one LIMIT=12 counter driven by the same inputs.
module tb_up_counter_ctrl;

    logic       clk, reset, start, stop, load;
    logic [3:0] load_val;
    logic [3:0] q15, q12;
    logic       busy15, tc15, done15, busy12, tc12, done12;
    int         n_tot = 0;
    int         n_bad = 0;

    up_counter_ctrl #(.WIDTH(4), .LIMIT(15)) u15 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .q(q15), .busy(busy15), .tc(tc15), .done(done15));

    up_counter_ctrl #(.WIDTH(4), .LIMIT(12)) u12 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .q(q12), .busy(busy12), .tc(tc12), .done(done12));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 0; stop = 0; load = 0; load_val = 0;
        #15 reset = 1'b0;
        #1;
        chk("rst_q", q15, 0);
        chk("rst_busy", busy15, 0);
        chk("rst_done", done15, 0);
        chk("rst_tc", tc15, 0);
        tick();

        // full count from 0
        start = 1; tick(); start = 0;
        chk("fc_busy0", busy15, 1);
        chk("fc_q0", q15, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("fc_q", q15, i);
            chk("fc_tc", tc15, (i == 15));
        end
        tick();
`ifdef UP_COUNTER_CTRL_AUTO_RELOAD_EN
        chk("wrap_q", q15, 0);
        chk("wrap_busy", busy15, 1);
        chk("wrap_tc", tc15, 0);
        tick(15);
        chk("wrap2_tc", tc15, 1);
        chk("wrap2_q", q15, 15);
`else
        chk("end_done", done15, 1);
        chk("end_q", q15, 15);
        chk("end_busy", busy15, 0);
        chk("end_tc", tc15, 0);
        tick(15);
        chk("hold_done", done15, 1);
        chk("hold_q", q15, 15);
`endif
        stop = 1; tick(); stop = 0;
        chk("idle_busy", busy15, 0);
        chk("idle_done", done15, 0);

        // asynchronous reset mid-count
        load = 1; load_val = 0; tick(); load = 0;
        start = 1; tick(); start = 0;
        tick(7);
        chk("mid_q7", q15, 7);
        #2 reset = 1'b1;
        #1;
        chk("arst_q", q15, 0);
        chk("arst_busy", busy15, 0);
        #1 reset = 1'b0;
        tick();

        // load and clamp
        load = 1; load_val = 4'd9; tick();
        chk("ld9_q12", q12, 9);
        load_val = 4'd14; tick(); load = 0;
        chk("ld14_q12", q12, 12);
        chk("ld14_q15", q15, 14);
        start = 1; tick(); start = 0;
        chk("ldst_tc12", tc12, 1);
        chk("ldst_busy12", busy12, 1);
        chk("ldst_tc15", tc15, 0);
        tick();
        chk("ld_q15", q15, 15);
        chk("ld_tc15", tc15, 1);
`ifndef UP_COUNTER_CTRL_AUTO_RELOAD_EN
        chk("ld_done12", done12, 1);
`endif
        stop = 1; tick(); stop = 0;

        // stop mid-count, then resume
        load = 1; load_val = 0; tick(); load = 0;
        start = 1; tick(); start = 0;
        tick(5);
        chk("sp_q5", q15, 5);
        stop = 1; tick(); stop = 0;
        chk("sp_busy", busy15, 0);
        chk("sp_hold", q15, 5);
        start = 1; tick(); start = 0;
        chk("rs_busy", busy15, 1);
        chk("rs_q_first", q15, 5);
        tick();
        chk("rs_q6", q15, 6);

        // load while counting
        tick(4);
        chk("lc_q10", q15, 10);
        load = 1; load_val = 4'd2; tick(); load = 0;
        chk("lc_q2", q15, 2);
        chk("lc_busy", busy15, 1);
        tick();
        chk("lc_q3", q15, 3);
        tick();
        chk("lc_q4", q15, 4);
        chk("lc_busy2", busy15, 1);

        // stop beats load in COUNT
        stop = 1; load = 1; load_val = 4'd9; tick(); stop = 0; load = 0;
        chk("sl_busy", busy15, 0);
        chk("sl_q", q15, 4);

        // count 4..15: interval LIMIT-q_start+1 = 12 edges to terminal action
        start = 1; tick(); start = 0;
        tick(11);
        chk("iv_tc", tc15, 1);
        tick();
`ifndef UP_COUNTER_CTRL_AUTO_RELOAD_EN
        chk("iv_done", done15, 1);
`endif
        load = 1; start = 1; load_val = 4'd3; tick(); load = 0; start = 0;
        chk("ls_q", q15, 3);
        chk("ls_busy", busy15, 1);
`ifndef UP_COUNTER_CTRL_AUTO_RELOAD_EN
        tick(13);
        chk("d2_done", done15, 1);
        start = 1; tick(); start = 0;
        chk("sd_q", q15, 0);
        chk("sd_busy", busy15, 1);
        chk("sd_done", done15, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
